// File: rtl/rca_pkg.sv
// Shared definitions for the nibble-serial adder: FSM states, slice width
// and the nibble index sizing helper.
package rca_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int unsigned NIBBLE_W = 4;

  function automatic int unsigned idx_width(input int unsigned nib);
    return (nib > 1) ? int'($clog2(nib)) : 1;
  endfunction

endpackage

// File: rtl/rca4.sv
// Combinational 4-bit ripple-carry slice.
module rca4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       ci,
  output logic [3:0] s,
  output logic       co
);

  logic [4:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int unsigned i = 0; i < 4; i++) begin
      s[i]   = a[i] ^ b[i] ^ c[i];
      c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end
    co = c[4];
  end

endmodule

// File: rtl/rca4_serial_ctrl.sv
// Wide adder built by stepping one rca4 slice across the operands, one
// nibble per clock, with valid/ready handshakes on both sides.
module rca4_serial_ctrl
  import rca_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NIB = WIDTH / NIBBLE_W;
  localparam int unsigned IW  = idx_width(NIB);

  state_t              state;
  logic [WIDTH-1:0]    a_r;
  logic [WIDTH-1:0]    b_r;
  logic                carry_r;
  logic [IW-1:0]       idx;
  logic [NIBBLE_W-1:0] sl_a;
  logic [NIBBLE_W-1:0] sl_b;
  logic [NIBBLE_W-1:0] sl_s;
  logic                sl_co;
  logic                accept;
  logic                last;

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (state == DONE);
  assign busy      = (state == ADD);
  assign last      = (idx == IW'(NIB - 1));

  always_comb begin
    sl_a = '0;
    sl_b = '0;
    for (int unsigned i = 0; i < NIB; i++) begin
      if (idx == IW'(i)) begin
        sl_a = a_r[i*NIBBLE_W +: NIBBLE_W];
        sl_b = b_r[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  rca4 u_slice (
    .a  (sl_a),
    .b  (sl_b),
    .ci (carry_r),
    .s  (sl_s),
    .co (sl_co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      idx     <= '0;
      sum     <= '0;
      co      <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      case (state)
        ADD: begin
          for (int unsigned i = 0; i < NIB; i++) begin
            if (idx == IW'(i)) sum[i*NIBBLE_W +: NIBBLE_W] <= sl_s;
          end
          carry_r <= sl_co;
          if (last) begin
            state <= DONE;
            co    <= sl_co;
            // sign of the result comes straight from the slice, not the sum register
            ovf   <= (a_r[WIDTH-1] == b_r[WIDTH-1]) && (sl_s[NIBBLE_W-1] != a_r[WIDTH-1]);
          end else begin
            idx <= idx + 1'b1;
          end
        end
        IDLE, DONE: begin
          if (accept) begin
            a_r     <= a;
            b_r     <= b;
            carry_r <= ci;
            idx     <= '0;
            sum     <= '0;
            state   <= ADD;
          end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
